// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generator and the PWM capture side.
//   PWM_COUNTER_BITS : default duty-code width; the PWM period is 2^PWM_COUNTER_BITS clocks.
//   cap_state_e      : capture state machine encoding (FLUSH, ACQ, LOCK).
//   maj3()           : 2-of-3 majority vote, used by the optional input deglitcher.
package pwm_pkg;

    localparam int PWM_COUNTER_BITS = 4;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,   // first window after reset; contains synchronizer fill
        ACQ   = 2'd1,   // reporting, waiting for two equal windows
        LOCK  = 2'd2    // reporting, consecutive windows agree
    } cap_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/pwm_in_cond.sv
// pwm_in_cond: conditions the asynchronous PWM input for counting.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset, all flops cleared to 0
//   pwm_in : asynchronous PWM waveform
//   s      : synchronized (and optionally deglitched) PWM bit
// Optional build macro: PWM_CAPTURE_DEGLITCH_EN
//   undefined : s is the output of a 2-flop synchronizer.
//   defined   : the second synchronizer stage plus two more history flops form a
//               3-sample window; s is the registered 2-of-3 majority of that window,
//               which removes isolated single-cycle highs and lows.
module pwm_in_cond
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef PWM_CAPTURE_DEGLITCH_EN
    // hist_q[0] is the previous synchronized sample, hist_q[1] the one before;
    // together with sync2_q they are the three most recent samples.
    logic [1:0] hist_q, hist_d;
    logic       s_q, s_d;

    always_comb begin
        hist_d = {hist_q[0], sync2_q};
        s_d    = maj3(sync2_q, hist_q[0], hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= 2'b00;
            s_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            s_q    <= s_d;
        end
    end

    assign s = s_q;
`else
    assign s = sync2_q;
`endif

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: recovers the duty code of a free-running PWM waveform whose period is
// 2^COUNTER_BITS clocks by counting high cycles over fixed windows of the same length.
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset; discards any partial window
//   pwm_in     : asynchronous PWM input
//   duty       : last measured duty code (all-ones when saturated)
//   duty_valid : one-cycle pulse, duty/sat were just updated
//   sat        : last reported window was high for every cycle
//   locked     : the last two windows produced equal counts (state == LOCK)
// Optional build macro: PWM_CAPTURE_DEGLITCH_EN (majority filter in pwm_in_cond).
// Handshake: duty_valid is a pure strobe with no ready; duty and sat are stable
// from the cycle duty_valid is high until the next duty_valid.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int COUNTER_BITS = PWM_COUNTER_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pwm_in,
    output logic [COUNTER_BITS:1] duty,
    output logic                  duty_valid,
    output logic                  sat,
    output logic                  locked
);

    // A window of 2^COUNTER_BITS cycles can count one more than the widest duty code.
    localparam logic [COUNTER_BITS:0] FULL_COUNT = {1'b1, {COUNTER_BITS{1'b0}}};

    logic s;

    logic [COUNTER_BITS-1:0] win_q, win_d;
    logic [COUNTER_BITS:0]   acc_q, acc_d;
    logic [COUNTER_BITS:0]   prev_q, prev_d;
    logic [COUNTER_BITS:1]   duty_q, duty_d;
    logic                    valid_q, valid_d;
    logic                    sat_q, sat_d;
    cap_state_e              state_q, state_d;

    logic                    win_end;
    logic                    report;
    logic [COUNTER_BITS:0]   sample;

    pwm_in_cond u_in_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .s      (s)
    );

    always_comb begin
        win_end = (win_q == {COUNTER_BITS{1'b1}});
        // Running count including the current cycle; at window end this is the result.
        sample  = acc_q + {{COUNTER_BITS{1'b0}}, s};

        win_d   = win_q + COUNTER_BITS'(1);
        acc_d   = win_end ? '0 : sample;
        prev_d  = prev_q;
        duty_d  = duty_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        state_d = state_q;
        report  = 1'b0;

        if (win_end) begin
            prev_d = sample;
            case (state_q)
                FLUSH: begin
                    state_d = ACQ;
                end
                ACQ: begin
                    report = 1'b1;
                    if (sample == prev_q) begin
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    report = 1'b1;
                    if (sample != prev_q) begin
                        state_d = ACQ;
                    end
                end
                default: begin
                    state_d = FLUSH;
                end
            endcase
        end

        if (report) begin
            valid_d = 1'b1;
            if (sample == FULL_COUNT) begin
                duty_d = '1;
                sat_d  = 1'b1;
            end else begin
                duty_d = sample[COUNTER_BITS-1:0];
                sat_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q   <= '0;
            acc_q   <= '0;
            prev_q  <= '0;
            duty_q  <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            state_q <= FLUSH;
        end else begin
            win_q   <= win_d;
            acc_q   <= acc_d;
            prev_q  <= prev_d;
            duty_q  <= duty_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = valid_q;
    assign sat        = sat_q;
    assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: self-checking bench for pwm_capture (COUNTER_BITS = 4).
// A cycle-level reference model tracks the driven PWM samples, predicts every
// window report into exp_q and the per-cycle duty_valid/locked values; a negedge
// monitor compares DUT outputs against it. Directed checks confirm the
// programmed duty codes independently of the model.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int CB  = 4;
    localparam int PER = 16;
`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam bit DEGLITCH = 1'b1;
`else
    localparam bit DEGLITCH = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic [CB:1]   duty;
    logic          duty_valid;
    logic          sat;
    logic          locked;

    always #5 clk = ~clk;

    pwm_capture #(.COUNTER_BITS(CB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .duty_valid (duty_valid),
        .sat        (sat),
        .locked     (locked)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- stimulus generator ----------------
    int d_cfg     = 0;
    int off_cfg   = 0;
    int pcnt      = 0;
    bit glitch_en = 1'b0;

    function automatic logic pwm_bit(input int cnt);
        int   pos;
        logic b;
        pos = (cnt + off_cfg) % PER;
        b   = (pos < d_cfg);
        if (glitch_en && (pos == 2 || pos == 11)) b = ~b;
        return b;
    endfunction

    // ---------------- reference model + scoreboard ----------------
    logic [5:0] exp_q[$];   // {sat, locked, duty}
    int         n_m = 0;
    int         tot = 0;
    int         rst_tot = 0;
    logic [4:0] acc_m = '0;
    logic [4:0] prev_m = '0;
    bit         flush_m = 1'b1;
    logic       locked_m = 1'b0;
    logic       exp_valid_now = 1'b0;
    logic       h1 = 0, h2 = 0, h3 = 0, h4 = 0, h5 = 0;  // samples taken 1..5 edges ago
    bit         first_after_rst = 1'b0;
    bit         started = 1'b0;

    task automatic model_step(input logic rst, input logic p);
        logic       s_m;
        logic [4:0] smp;
        tot++;
        exp_valid_now = 1'b0;
        if (!rst) begin
            n_m = 0; acc_m = '0; prev_m = '0; flush_m = 1'b1; locked_m = 1'b0;
            h1 = 0; h2 = 0; h3 = 0; h4 = 0; h5 = 0;
            rst_tot = tot;
            first_after_rst = 1'b1;
        end else begin
            n_m++;
            if (DEGLITCH) s_m = (h3 & h4) | (h3 & h5) | (h4 & h5);
            else          s_m = h2;
            h5 = h4; h4 = h3; h3 = h2; h2 = h1; h1 = p;
            if (n_m % PER == 0) begin
                smp = acc_m + {4'b0, s_m};
                acc_m = '0;
                if (!flush_m) begin
                    locked_m = (smp == prev_m);
                    exp_q.push_back({smp[4], locked_m, (smp[4] ? 4'hF : smp[3:0])});
                    exp_valid_now = 1'b1;
                end
                flush_m = 1'b0;
                prev_m  = smp;
            end else begin
                acc_m = acc_m + {4'b0, s_m};
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic rst);
        logic p;
        p = pwm_bit(pcnt);
        pcnt++;
        rst_n  = rst;
        pwm_in = p;
        @(posedge clk);
        model_step(rst, p);
        #1;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b1);
    endtask

    task automatic do_reset();
        tick(1'b0);
        tick(1'b0);
        started = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic [5:0]  e_mon;
    int          last_valid_tot = 0;
    logic [CB:1] last_duty = '0;
    logic        last_sat = 1'b0;
    logic        last_locked = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            check_eq("duty_valid", duty_valid, exp_valid_now);
            check_eq("locked", locked, locked_m);
            if (duty_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_report", 1, 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check_eq("report_duty", duty, e_mon[3:0]);
                    check_eq("report_sat", sat, e_mon[5]);
                    check_eq("report_locked", locked, e_mon[4]);
                end
                if (first_after_rst) check_eq("first_valid_latency", tot - rst_tot, 32);
                else                 check_eq("valid_spacing", tot - last_valid_tot, PER);
                first_after_rst = 1'b0;
                last_valid_tot  = tot;
                last_duty       = duty;
                last_sat        = sat;
                last_locked     = locked;
            end
        end
    end

    // ---------------- test sequence ----------------
    int exp_d;

    initial begin
        // 1: duty 5, arbitrary phase
        d_cfg = 5; off_cfg = 7;
        do_reset();
        check_eq("reset_duty", duty, 0);
        check_eq("reset_valid", duty_valid, 0);
        check_eq("reset_locked", locked, 0);
        run(49);
        check_eq("t1_duty", last_duty, 5);
        check_eq("t1_sat", last_sat, 0);
        check_eq("t1_locked", last_locked, 1);

        // 3: switch 5 -> 9 mid-window while locked
        run(7);
        d_cfg = 9;
        run(9);
        check_eq("t3_trans_range", (last_duty >= 5 && last_duty <= 9), 1);
        run(40);
        check_eq("t3_duty", last_duty, 9);
        check_eq("t3_locked", last_locked, 1);

        // 4: one-cycle reset mid-window while locked
        run(5);
        tick(1'b0);
        check_eq("t4_duty", duty, 0);
        check_eq("t4_valid", duty_valid, 0);
        check_eq("t4_sat", sat, 0);
        check_eq("t4_locked", locked, 0);
        check_eq("t4_state", int'(dut.state_q), int'(FLUSH));
        run(49);
        check_eq("t4_relock", last_locked, 1);

        // 2: constant low, then constant high
        d_cfg = 0;
        do_reset();
        run(49);
        check_eq("t2_low_duty", last_duty, 0);
        check_eq("t2_low_sat", last_sat, 0);
        check_eq("t2_low_locked", last_locked, 1);
        d_cfg = 16;
        run(65);
        check_eq("t2_high_duty", last_duty, 15);
        check_eq("t2_high_sat", last_sat, 1);
        check_eq("t2_high_locked", last_locked, 1);

        // 5: sweep every duty code at four phase offsets
        for (int d = 0; d < PER; d++) begin
            for (int k = 0; k < 4; k++) begin
                d_cfg   = d;
                off_cfg = (k * 5 + d) % PER;
                run(65);
                exp_d = (DEGLITCH && d == 1) ? 0 : d;
                check_eq($sformatf("sweep_d%0d_o%0d", d, off_cfg), last_duty, exp_d);
                check_eq($sformatf("sweep_lock_d%0d_o%0d", d, off_cfg), last_locked, 1);
            end
        end

        // 6: narrow pulse and single-cycle glitches
        d_cfg = 1; off_cfg = 3;
        run(65);
        check_eq("t6_duty1", last_duty, DEGLITCH ? 0 : 1);
        d_cfg = 6; glitch_en = 1'b1;
        run(65);
        check_eq("t6_glitch_duty", last_duty, 6);
        check_eq("t6_glitch_locked", last_locked, 1);
        glitch_en = 1'b0;

        run(2);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
